prefetch_stream_buffer: RTL and testbench

- Parametrised successor to the single-line instruction prefetcher: a DEPTH-entry circular stream buffer that runs ahead of the I-cache by up to DEPTH sequential lines after a miss.
- Sits between I-cache miss logic and the AXI read port.
- The I-cache probes all entries combinationally and consumes a hit line in one cycle.
- New behaviour:
  - multi-line run-ahead;
  - hit on any entry, with older entries dropped;
  - stream restart mid-burst with drain;
  - stop at page boundary;
  - flush.

---
 rtl/prefetch_stream_buffer_pkg.sv | 27 ++
 rtl/prefetch_stream_buffer_burst_reader.sv | 116 +++++++++++
 rtl/prefetch_stream_buffer.sv | 169 ++++++++++++++++
 tb/tb_prefetch_stream_buffer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_stream_buffer_pkg.sv
// Shared types and default geometry for the prefetch stream buffer and its burst reader.
package pf_pkg;

    localparam int PF_LINE_ADDR_W    = 27;
    localparam int PF_WORD_W         = 32;
    localparam int PF_LINE_WORDS     = 8;
    localparam int PF_DEPTH          = 4;
    localparam int PF_PAGE_LINE_BITS = 7;

    localparam int LINE_OFF_W = $clog2(PF_LINE_WORDS * PF_WORD_W / 8);
    localparam int PTR_W      = $clog2(PF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_READ = 2'd2
    } pf_state_e;

    typedef logic [PF_LINE_WORDS-1:0][PF_WORD_W-1:0] pf_line_t;

    typedef struct packed {
        logic                      valid;
        logic [PF_LINE_ADDR_W-1:0] line_addr;
        pf_line_t                  data;
    } pf_slot_t;

endpackage

// File: rtl/prefetch_stream_buffer_burst_reader.sv
// One AXI read burst per line: address phase, beat collection into staging, and a commit/drop pulse.
module pf_burst_reader
    import pf_pkg::*;
#(
    parameter  int LINE_ADDR_W = PF_LINE_ADDR_W,
    parameter  int WORD_W      = PF_WORD_W,
    parameter  int LINE_WORDS  = PF_LINE_WORDS,
    localparam int OFF_W       = $clog2(LINE_WORDS * WORD_W / 8),
    localparam int CNT_W       = $clog2(LINE_WORDS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start_i,
    input  logic [LINE_ADDR_W-1:0]       start_line_addr_i,
    input  logic                         kill_i,
    output logic [LINE_ADDR_W+OFF_W-1:0] axi_araddr_o,
    output logic                         axi_arvalid_o,
    input  logic                         axi_arready_i,
    input  logic [WORD_W-1:0]            axi_rdata_i,
    input  logic                         axi_rvalid_i,
    input  logic                         axi_rlast_i,
    output logic                         axi_rready_o,
    output logic                         line_done_o,
    output logic                         line_discard_o,
    output logic [LINE_WORDS*WORD_W-1:0] line_data_o,
    output pf_state_e                    state_o
);

    pf_state_e                         state_r;
    logic [LINE_ADDR_W+OFF_W-1:0]      araddr_r;
    logic                              arvalid_r;
    logic                              rready_r;
    logic                              discard_r;
    logic [CNT_W-1:0]                  cnt_r;
    logic [LINE_WORDS-1:0][WORD_W-1:0] staging_r;
    logic [LINE_WORDS-1:0][WORD_W-1:0] line_data_s;
    logic                              beat_s;
    logic                              last_s;

    assign beat_s = (state_r == S_READ) && axi_rvalid_i;
    assign last_s = beat_s && axi_rlast_i;

    // Final beat is merged straight in so the line commits on the rlast edge.
    always_comb begin
        line_data_s        = staging_r;
        line_data_s[cnt_r] = axi_rdata_i;
    end

    // Burst sequencing; a kill never retracts arvalid, it only marks the line for dropping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= S_IDLE;
            araddr_r  <= '0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            discard_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        araddr_r  <= {start_line_addr_i, {OFF_W{1'b0}}};
                        arvalid_r <= 1'b1;
                        discard_r <= 1'b0;
                        state_r   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (kill_i) begin
                        discard_r <= 1'b1;
                    end
                    if (axi_arready_i) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        cnt_r     <= '0;
                        state_r   <= S_READ;
                    end
                end
                S_READ: begin
                    if (kill_i) begin
                        discard_r <= 1'b1;
                    end
                    if (beat_s) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                    if (last_s) begin
                        rready_r  <= 1'b0;
                        discard_r <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

    // Staging words carry no reset; only committed lines are ever observed.
    always_ff @(posedge clock) begin
        if (beat_s) begin
            staging_r[cnt_r] <= axi_rdata_i;
        end
    end

    assign axi_araddr_o   = araddr_r;
    assign axi_arvalid_o  = arvalid_r;
    assign axi_rready_o   = rready_r;
    assign line_done_o    = last_s && !discard_r && !kill_i;
    assign line_discard_o = last_s && (discard_r || kill_i);
    assign line_data_o    = line_data_s;
    assign state_o        = state_r;

endmodule

// File: rtl/prefetch_stream_buffer.sv
// DEPTH-slot circular stream buffer that runs ahead of the I-cache after a miss, stopping at page ends.
module prefetch_stream_buffer
    import pf_pkg::*;
#(
    parameter  int LINE_ADDR_W    = PF_LINE_ADDR_W,
    parameter  int WORD_W         = PF_WORD_W,
    parameter  int LINE_WORDS     = PF_LINE_WORDS,
    parameter  int DEPTH          = PF_DEPTH,
    parameter  int PAGE_LINE_BITS = PF_PAGE_LINE_BITS,
    localparam int OFF_W          = $clog2(LINE_WORDS * WORD_W / 8),
    localparam int PW             = $clog2(DEPTH),
    localparam int LINE_W         = LINE_WORDS * WORD_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         miss_valid_i,
    input  logic [LINE_ADDR_W-1:0]       miss_line_addr_i,
    input  logic                         flush_i,
    input  logic [LINE_ADDR_W-1:0]       lookup_line_addr_i,
    output logic                         hit_o,
    output logic [LINE_W-1:0]            hit_data_o,
    input  logic                         consume_i,
    output logic                         busy_o,
    output logic [PW:0]                  count_o,
    output logic [LINE_ADDR_W+OFF_W-1:0] axi_araddr_o,
    output logic [7:0]                   axi_arlen_o,
    output logic                         axi_arvalid_o,
    input  logic                         axi_arready_i,
    input  logic [WORD_W-1:0]            axi_rdata_i,
    input  logic                         axi_rvalid_i,
    input  logic                         axi_rlast_i,
    output logic                         axi_rready_o
);

    localparam logic [PW:0]          DEPTH_C   = (PW + 1)'(DEPTH);
    localparam logic [LINE_ADDR_W-1:0] PAGE_MASK = LINE_ADDR_W'((64'd1 << PAGE_LINE_BITS) - 64'd1);

    logic [DEPTH-1:0]       slot_valid_r;
    logic [LINE_ADDR_W-1:0] slot_addr_r [DEPTH];
    logic [LINE_W-1:0]      slot_data_r [DEPTH];
    logic [PW-1:0]          head_r;
    logic [PW-1:0]          tail_r;
    logic [PW:0]            count_r;
    logic [LINE_ADDR_W-1:0] next_fetch_r;
    logic                   stream_active_r;

    logic                   kill_s;
    logic                   consume_s;
    logic                   hit_s;
    logic [PW-1:0]          hit_idx_s;
    logic [LINE_W-1:0]      hit_data_s;
    logic [PW-1:0]          k_off_s;
    logic [DEPTH-1:0]       drop_s;
    logic [PW:0]            dropped_s;
    logic [PW:0]            count_next_s;
    logic                   page_end_s;
    logic                   start_s;
    logic [LINE_ADDR_W-1:0] start_addr_s;
    logic                   line_done_s;
    logic                   line_discard_s;
    logic [LINE_W-1:0]      line_data_s;
    pf_state_e              reader_state_s;

    function automatic logic [PW-1:0] ring_off(input logic [PW-1:0] idx, input logic [PW-1:0] base);
        return idx - base;
    endfunction

    assign kill_s    = miss_valid_i || flush_i;
    assign consume_s = consume_i && hit_s && !kill_s;

    // Fully associative probe; sequential fill leaves at most one matching slot.
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = '0;
        hit_data_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s      = hit_s | (slot_valid_r[i] && (slot_addr_r[i] == lookup_line_addr_i));
            hit_idx_s  = hit_idx_s | ({PW{slot_valid_r[i] && (slot_addr_r[i] == lookup_line_addr_i)}} & PW'(i));
            hit_data_s = hit_data_s | ({LINE_W{slot_valid_r[i] && (slot_addr_r[i] == lookup_line_addr_i)}} & slot_data_r[i]);
        end
    end

    // Consuming slot k retires every slot from head up to and including k.
    always_comb begin
        k_off_s = ring_off(hit_idx_s, head_r);
        drop_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            drop_s[i] = ring_off(PW'(i), head_r) <= k_off_s;
        end
        dropped_s    = {1'b0, k_off_s} + (PW + 1)'(1);
        count_next_s = count_r + (PW + 1)'(line_done_s) - (consume_s ? dropped_s : (PW + 1)'(0));
        page_end_s   = (PAGE_LINE_BITS != 0) && ((next_fetch_r & PAGE_MASK) == PAGE_MASK);
        start_s      = miss_valid_i || (stream_active_r && !flush_i && (count_r < DEPTH_C));
        start_addr_s = miss_valid_i ? (miss_line_addr_i + LINE_ADDR_W'(1)) : next_fetch_r;
    end

    // Ring pointers, occupancy and stream pointer; a miss or flush overrides consume and commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_valid_r    <= '0;
            head_r          <= '0;
            tail_r          <= '0;
            count_r         <= '0;
            next_fetch_r    <= '0;
            stream_active_r <= 1'b0;
        end else if (kill_s) begin
            slot_valid_r    <= '0;
            head_r          <= '0;
            tail_r          <= '0;
            count_r         <= '0;
            stream_active_r <= miss_valid_i;
            if (miss_valid_i) begin
                next_fetch_r <= miss_line_addr_i + LINE_ADDR_W'(1);
            end
        end else begin
            slot_valid_r <= (slot_valid_r & ~(consume_s ? drop_s : DEPTH'(0)))
                          | (line_done_s ? (DEPTH'(1) << tail_r) : DEPTH'(0));
            count_r      <= count_next_s;
            if (consume_s) begin
                head_r <= hit_idx_s + PW'(1);
            end
            if (line_done_s) begin
                tail_r       <= tail_r + PW'(1);
                next_fetch_r <= next_fetch_r + LINE_ADDR_W'(1);
                if (page_end_s) begin
                    stream_active_r <= 1'b0;
                end
            end
        end
    end

    // The in-flight line is always next_fetch, because any restart discards it.
    always_ff @(posedge clock) begin
        if (line_done_s && !line_discard_s) begin
            slot_addr_r[tail_r] <= next_fetch_r;
            slot_data_r[tail_r] <= line_data_s;
        end
    end

    pf_burst_reader #(
        .LINE_ADDR_W (LINE_ADDR_W),
        .WORD_W      (WORD_W),
        .LINE_WORDS  (LINE_WORDS)
    ) u_reader (
        .clock             (clock),
        .reset             (reset),
        .start_i           (start_s),
        .start_line_addr_i (start_addr_s),
        .kill_i            (kill_s),
        .axi_araddr_o      (axi_araddr_o),
        .axi_arvalid_o     (axi_arvalid_o),
        .axi_arready_i     (axi_arready_i),
        .axi_rdata_i       (axi_rdata_i),
        .axi_rvalid_i      (axi_rvalid_i),
        .axi_rlast_i       (axi_rlast_i),
        .axi_rready_o      (axi_rready_o),
        .line_done_o       (line_done_s),
        .line_discard_o    (line_discard_s),
        .line_data_o       (line_data_s),
        .state_o           (reader_state_s)
    );

    assign hit_o       = hit_s;
    assign hit_data_o  = hit_data_s;
    assign busy_o      = reader_state_s != S_IDLE;
    assign count_o     = count_r;
    assign axi_arlen_o = 8'(LINE_WORDS - 1);

endmodule

// File: tb/tb_prefetch_stream_buffer.sv
// Self-checking bench: AXI slave model plus an AR-address scoreboard and line-content probes.
module tb_prefetch_stream_buffer;

    localparam int AW     = 27;
    localparam int WW     = 32;
    localparam int LW     = 8;
    localparam int LINE_W = LW * WW;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              miss_valid_i = 1'b0;
    logic [AW-1:0]     miss_line_addr_i = '0;
    logic              flush_i = 1'b0;
    logic [AW-1:0]     lookup_line_addr_i = '0;
    logic              hit_o;
    logic [LINE_W-1:0] hit_data_o;
    logic              consume_i = 1'b0;
    logic              busy_o;
    logic [2:0]        count_o;
    logic [31:0]       axi_araddr_o;
    logic [7:0]        axi_arlen_o;
    logic              axi_arvalid_o;
    logic              axi_arready_i = 1'b0;
    logic [WW-1:0]     axi_rdata_i = '0;
    logic              axi_rvalid_i = 1'b0;
    logic              axi_rlast_i = 1'b0;
    logic              axi_rready_o;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int stall_until = 0;
    int ar_count = 0;
    int s_beat   = 0;
    logic s_pend = 1'b0;
    logic [AW-1:0] s_line = '0;
    logic [31:0] exp_ar_q[$];

    prefetch_stream_buffer dut (
        .clock              (clock),
        .reset              (reset),
        .miss_valid_i       (miss_valid_i),
        .miss_line_addr_i   (miss_line_addr_i),
        .flush_i            (flush_i),
        .lookup_line_addr_i (lookup_line_addr_i),
        .hit_o              (hit_o),
        .hit_data_o         (hit_data_o),
        .consume_i          (consume_i),
        .busy_o             (busy_o),
        .count_o            (count_o),
        .axi_araddr_o       (axi_araddr_o),
        .axi_arlen_o        (axi_arlen_o),
        .axi_arvalid_o      (axi_arvalid_o),
        .axi_arready_i      (axi_arready_i),
        .axi_rdata_i        (axi_rdata_i),
        .axi_rvalid_i       (axi_rvalid_i),
        .axi_rlast_i        (axi_rlast_i),
        .axi_rready_o       (axi_rready_o)
    );

    always #5 clock = ~clock;

    // Free-running cycle counter used to time arready stalls.
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [WW-1:0] beat_word(input logic [AW-1:0] line, input int w);
        return {line[23:0], 8'(w)} ^ 32'h5A00_0000;
    endfunction

    function automatic logic [LINE_W-1:0] line_model(input logic [AW-1:0] line);
        logic [LINE_W-1:0] r;
        for (int w = 0; w < LW; w++) r[w*WW +: WW] = beat_word(line, w);
        return r;
    endfunction

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_lines(input logic [AW-1:0] first, input int n);
        for (int i = 0; i < n; i++) exp_ar_q.push_back({first + AW'(i), 5'b0});
    endtask

    task automatic do_miss(input logic [AW-1:0] addr, input logic fl);
        miss_valid_i = 1'b1;
        miss_line_addr_i = addr;
        flush_i = fl;
        tick(1);
        miss_valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [AW-1:0] addr, input logic exp_hit);
        lookup_line_addr_i = addr;
        #1;
        check({tag, "_hit"}, LINE_W'(hit_o), LINE_W'(exp_hit));
        if (exp_hit) check({tag, "_data"}, hit_data_o, line_model(addr));
    endtask

    task automatic wait_count(input string tag, input int target, input int budget);
        int i = 0;
        while (int'(count_o) != target && i < budget) begin
            tick(1);
            i++;
        end
        check(tag, LINE_W'(count_o), LINE_W'(target));
    endtask

    task automatic wait_beat(input string tag, input int beat, input int budget);
        int i = 0;
        while (!(axi_rvalid_i && s_beat == beat) && i < budget) begin
            tick(1);
            i++;
        end
        check(tag, LINE_W'(s_beat), LINE_W'(beat));
    endtask

    // AXI slave: handshakes are judged mid-cycle, responses driven just after the edge.
    initial begin
        logic ar_fire;
        logic r_fire;
        logic [31:0] exp_a;
        forever begin
            @(negedge clock);
            ar_fire = !reset && axi_arvalid_o && axi_arready_i;
            r_fire  = !reset && axi_rvalid_i && axi_rready_o;
            if (ar_fire) begin
                if (exp_ar_q.size() > 0) exp_a = exp_ar_q.pop_front();
                else exp_a = 32'hFFFF_FFFF;
                check("ar_addr", LINE_W'(axi_araddr_o), LINE_W'(exp_a));
                check("ar_len", LINE_W'(axi_arlen_o), LINE_W'(LW - 1));
            end
            @(posedge clock);
            #1;
            if (reset) begin
                s_pend = 1'b0;
                s_beat = 0;
            end else begin
                if (r_fire) begin
                    if (s_beat == LW - 1) s_pend = 1'b0;
                    else s_beat++;
                end
                if (ar_fire) begin
                    s_pend = 1'b1;
                    s_beat = 0;
                    s_line = axi_araddr_o[31:5];
                    ar_count++;
                end
            end
            axi_arready_i = (cyc >= stall_until);
            axi_rvalid_i  = s_pend;
            axi_rdata_i   = beat_word(s_line, s_beat);
            axi_rlast_i   = s_pend && (s_beat == LW - 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tick(3);
        check("rst_hit", LINE_W'(hit_o), '0);
        check("rst_busy", LINE_W'(busy_o), '0);
        check("rst_count", LINE_W'(count_o), '0);
        check("rst_arvalid", LINE_W'(axi_arvalid_o), '0);
        check("rst_rready", LINE_W'(axi_rready_o), '0);
        check("rst_araddr", LINE_W'(axi_araddr_o), '0);
        reset = 1'b0;
        tick(1);

        // Run-ahead fills all four slots, then stops.
        push_lines(27'h101, 4);
        do_miss(27'h100, 1'b0);
        check("miss_to_ar", LINE_W'(axi_arvalid_o), LINE_W'(1));
        check("miss_to_ar_addr", LINE_W'(axi_araddr_o), LINE_W'({27'h101, 5'b0}));
        wait_count("fill4", 4, 400);
        tick(20);
        check("fill4_ar_count", LINE_W'(ar_count), LINE_W'(4));
        check("fill4_q_empty", LINE_W'(exp_ar_q.size()), '0);
        check("fill4_idle", LINE_W'(busy_o), '0);
        probe("l101", 27'h101, 1'b1);
        probe("l104", 27'h104, 1'b1);
        probe("l105", 27'h105, 1'b0);

        // Consume mid-buffer drops older entries and resumes fetching.
        push_lines(27'h105, 3);
        lookup_line_addr_i = 27'h103;
        consume_i = 1'b1;
        #1;
        check("cons_hit", LINE_W'(hit_o), LINE_W'(1));
        check("cons_data", hit_data_o, line_model(27'h103));
        tick(1);
        consume_i = 1'b0;
        check("cons_count", LINE_W'(count_o), LINE_W'(1));
        probe("cons_l104", 27'h104, 1'b1);
        probe("cons_l103", 27'h103, 1'b0);
        probe("cons_l101", 27'h101, 1'b0);
        wait_count("refill4", 4, 400);
        tick(20);
        check("refill_q_empty", LINE_W'(exp_ar_q.size()), '0);
        probe("l107", 27'h107, 1'b1);

        // Restart during a burst: the in-flight line is drained and dropped.
        push_lines(27'h101, 1);
        do_miss(27'h100, 1'b0);
        wait_beat("beat3", 3, 100);
        push_lines(27'h201, 4);
        do_miss(27'h200, 1'b0);
        check("drain_rready", LINE_W'(axi_rready_o), LINE_W'(1));
        check("drain_count", LINE_W'(count_o), '0);
        wait_count("restart4", 4, 400);
        tick(20);
        probe("rs_l101", 27'h101, 1'b0);
        probe("rs_l201", 27'h201, 1'b1);
        probe("rs_l204", 27'h204, 1'b1);
        check("restart_q_empty", LINE_W'(exp_ar_q.size()), '0);

        // Page boundary stops the stream at line 0x17F.
        push_lines(27'h17D, 3);
        do_miss(27'h17C, 1'b0);
        wait_count("page3", 3, 400);
        tick(20);
        check("page_busy", LINE_W'(busy_o), '0);
        check("page_count", LINE_W'(count_o), LINE_W'(3));
        check("page_q_empty", LINE_W'(exp_ar_q.size()), '0);
        probe("pg_l17f", 27'h17F, 1'b1);
        probe("pg_l180", 27'h180, 1'b0);

        // Miss and flush together: the miss wins.
        push_lines(27'h301, 4);
        do_miss(27'h300, 1'b1);
        check("mf_arvalid", LINE_W'(axi_arvalid_o), LINE_W'(1));
        check("mf_araddr", LINE_W'(axi_araddr_o), LINE_W'({27'h301, 5'b0}));
        wait_count("mf4", 4, 400);
        tick(20);

        // Flush while AR is stalled: request held stable, line discarded.
        push_lines(27'h401, 1);
        stall_until = cyc + 6;
        do_miss(27'h400, 1'b0);
        check("st_arvalid", LINE_W'(axi_arvalid_o), LINE_W'(1));
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("st_hold_arvalid", LINE_W'(axi_arvalid_o), LINE_W'(1));
            check("st_hold_araddr", LINE_W'(axi_araddr_o), LINE_W'({27'h401, 5'b0}));
            tick(1);
        end
        tick(30);
        check("st_busy", LINE_W'(busy_o), '0);
        check("st_count", LINE_W'(count_o), '0);
        check("st_q_empty", LINE_W'(exp_ar_q.size()), '0);
        probe("st_l401", 27'h401, 1'b0);

        // Reset in the middle of a read burst.
        push_lines(27'h501, 1);
        do_miss(27'h500, 1'b0);
        wait_beat("rst_beat2", 2, 100);
        reset = 1'b1;
        tick(1);
        check("mrst_busy", LINE_W'(busy_o), '0);
        check("mrst_arvalid", LINE_W'(axi_arvalid_o), '0);
        check("mrst_rready", LINE_W'(axi_rready_o), '0);
        check("mrst_araddr", LINE_W'(axi_araddr_o), '0);
        check("mrst_count", LINE_W'(count_o), '0);
        probe("mrst_l401", 27'h401, 1'b0);
        probe("mrst_l304", 27'h304, 1'b0);
        probe("mrst_l000", 27'h000, 1'b0);
        reset = 1'b0;
        tick(2);
        push_lines(27'h601, 4);
        do_miss(27'h600, 1'b0);
        check("pr_arvalid", LINE_W'(axi_arvalid_o), LINE_W'(1));
        check("pr_araddr", LINE_W'(axi_araddr_o), LINE_W'({27'h601, 5'b0}));
        wait_count("pr4", 4, 400);
        tick(20);
        probe("pr_l602", 27'h602, 1'b1);
        check("pr_q_empty", LINE_W'(exp_ar_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
